// File: rtl/auto_shift_controller_pkg.sv
// Shared gear, shift-code and FSM-state definitions for the transmission path.
// The transmission and RPM model import the same encodings.
package auto_shift_controller_pkg;

  localparam logic [3:0] GEAR_1 = 4'b0001;
  localparam logic [3:0] GEAR_2 = 4'b0010;
  localparam logic [3:0] GEAR_3 = 4'b0100;
  localparam logic [3:0] GEAR_4 = 4'b1000;

  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] SHIFT_UP   = 2'b10;
  localparam logic [1:0] SHIFT_DN   = 2'b01;

  localparam logic [1:0] PEDAL_ACCEL = 2'b10;
  localparam logic [1:0] PEDAL_DECEL = 2'b01;

  typedef enum logic [1:0] {
    CRUISE  = 2'd0,
    QUAL_UP = 2'd1,
    QUAL_DN = 2'd2,
    LOCKOUT = 2'd3
  } shift_state_e;

endpackage

// File: rtl/auto_shift_controller_shift_timer.sv
// Loadable 32-bit up-counter with clear and enable; flags the last count before TERMINAL.
// Used both as the dwell qualifier and as the post-shift lockout timer.
module shift_timer #(
  parameter logic [31:0] TERMINAL = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [31:0] i_loadVal,
  input  logic        i_en,
  output logic        o_tc
);

  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_tc = (r_count == TERMINAL - 32'd1);

endmodule

// File: rtl/auto_shift_controller.sv
// Automatic gearbox controller: qualifies rpm against thresholds, steps one gear per
// decision, pulses shift_req and holds off further decisions during a lockout window.
module auto_shift_controller
  import auto_shift_controller_pkg::*;
#(
  parameter logic [31:0] UP_RPM         = 32'h0003_FFFF,
  parameter logic [31:0] DOWN_RPM       = 32'h0000_03FF,
  parameter logic [31:0] QUAL_CYCLES    = 32'd1000,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        auto,
  input  logic [31:0] rpm,
  input  logic [1:0]  pedals,
  output logic [3:0]  gears,
  output logic [1:0]  shift_req,
  output logic        locked
);

  shift_state_e r_state;
  logic [3:0]   r_gears;
  logic [1:0]   r_shiftReq;
  logic         r_locked;

  logic w_upCond;
  logic w_dnCond;
  logic w_commitUp;
  logic w_commitDn;
  logic w_qualClear;
  logic w_qualLoad;
  logic w_qualEn;
  logic w_qualTc;
  logic w_lockClear;
  logic w_lockEn;
  logic w_lockTc;

  // Gear limits and the opposing pedal mask each direction independently.
  assign w_upCond = auto && (rpm > UP_RPM) && (r_gears != GEAR_4) && (pedals != PEDAL_DECEL);
  assign w_dnCond = auto && (rpm < DOWN_RPM) && (r_gears != GEAR_1) && (pedals != PEDAL_ACCEL);

  always_comb begin
    w_commitUp = 1'b0;
    w_commitDn = 1'b0;
    unique case (r_state)
      CRUISE: begin
        w_commitUp = w_upCond && (QUAL_CYCLES == 32'd1);
        w_commitDn = !w_upCond && w_dnCond && (QUAL_CYCLES == 32'd1);
      end
      QUAL_UP: w_commitUp = w_upCond && w_qualTc;
      QUAL_DN: w_commitDn = w_dnCond && w_qualTc;
      default: ;
    endcase
  end

  // The qualify count restarts at 1 on entry and drops to 0 whenever dwell is broken or committed.
  assign w_qualLoad  = (r_state == CRUISE) && (w_upCond || w_dnCond) && !w_commitUp && !w_commitDn;
  assign w_qualEn    = (((r_state == QUAL_UP) && w_upCond) || ((r_state == QUAL_DN) && w_dnCond))
                       && !w_commitUp && !w_commitDn;
  assign w_qualClear = !w_qualLoad && !w_qualEn;
  assign w_lockEn    = (r_state == LOCKOUT) && !w_lockTc;
  assign w_lockClear = !w_lockEn;

  shift_timer #(.TERMINAL(QUAL_CYCLES)) u_qualTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_qualClear),
    .i_load    (w_qualLoad),
    .i_loadVal (32'd1),
    .i_en      (w_qualEn),
    .o_tc      (w_qualTc)
  );

  shift_timer #(.TERMINAL(LOCKOUT_CYCLES)) u_lockTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_lockClear),
    .i_load    (1'b0),
    .i_loadVal (32'd0),
    .i_en      (w_lockEn),
    .o_tc      (w_lockTc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CRUISE;
      r_gears    <= GEAR_1;
      r_shiftReq <= SHIFT_NONE;
      r_locked   <= 1'b0;
    end else begin
      r_shiftReq <= SHIFT_NONE;
      if (w_commitUp) begin
        r_gears    <= {r_gears[2:0], 1'b0};
        r_shiftReq <= SHIFT_UP;
        r_locked   <= 1'b1;
        r_state    <= LOCKOUT;
      end else if (w_commitDn) begin
        r_gears    <= {1'b0, r_gears[3:1]};
        r_shiftReq <= SHIFT_DN;
        r_locked   <= 1'b1;
        r_state    <= LOCKOUT;
      end else begin
        unique case (r_state)
          CRUISE: begin
            if (w_upCond) r_state <= QUAL_UP;
            else if (w_dnCond) r_state <= QUAL_DN;
          end
          QUAL_UP: if (!w_upCond) r_state <= CRUISE;
          QUAL_DN: if (!w_dnCond) r_state <= CRUISE;
          LOCKOUT: begin
            if (w_lockTc) begin
              r_state  <= CRUISE;
              r_locked <= 1'b0;
            end
          end
          default: r_state <= CRUISE;
        endcase
      end
    end
  end

  assign gears     = r_gears;
  assign shift_req = r_shiftReq;
  assign locked    = r_locked;

endmodule

// File: tb/tb_auto_shift_controller.sv
// Directed bench for auto_shift_controller with a queue of expected outputs per cycle.
module tb_auto_shift_controller;

  logic        clk;
  logic        rst_n;
  logic        auto;
  logic [31:0] rpm;
  logic [1:0]  pedals;
  logic [3:0]  gears;
  logic [1:0]  shift_req;
  logic        locked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic [1:0] sr;
    logic       lk;
  } exp_t;

  exp_t expQ[$];

  auto_shift_controller #(
    .UP_RPM         (32'd1000),
    .DOWN_RPM       (32'd100),
    .QUAL_CYCLES    (32'd4),
    .LOCKOUT_CYCLES (32'd8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .auto      (auto),
    .rpm       (rpm),
    .pedals    (pedals),
    .gears     (gears),
    .shift_req (shift_req),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic a, input logic [31:0] r, input logic [1:0] p);
    auto   = a;
    rpm    = r;
    pedals = p;
  endtask

  task automatic pushExpect(input string tag, input logic [3:0] g, input logic [1:0] sr, input logic lk);
    exp_t e;
    e.tag = tag;
    e.g   = g;
    e.sr  = sr;
    e.lk  = lk;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    e = expQ.pop_front();
    checks++;
    assert ({gears, shift_req, locked} === {e.g, e.sr, e.lk})
    else begin
      errors++;
      $error("[TB] FAIL %s: observed gears=%b shift_req=%b locked=%b, expected gears=%b shift_req=%b locked=%b",
             e.tag, gears, shift_req, locked, e.g, e.sr, e.lk);
    end
  endtask

  // One clock: drive inputs, queue the expected post-edge outputs, then compare after the edge.
  task automatic cycle(input string tag, input logic a, input logic [31:0] r, input logic [1:0] p,
                       input logic [3:0] g, input logic [1:0] sr, input logic lk);
    applyStimulus(a, r, p);
    pushExpect(tag, g, sr, lk);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic holdRun(input string tag, input logic a, input logic [31:0] r, input logic [1:0] p,
                         input logic [3:0] g, input int n);
    for (int i = 0; i < n; i++) cycle(tag, a, r, p, g, 2'b00, 1'b0);
  endtask

  task automatic qualifyRun(input string tag, input logic a, input logic [31:0] r, input logic [1:0] p,
                            input logic [3:0] gFrom, input logic [3:0] gTo, input logic [1:0] sr);
    for (int i = 0; i < 3; i++) cycle({tag, "_dwell"}, a, r, p, gFrom, 2'b00, 1'b0);
    cycle({tag, "_commit"}, a, r, p, gTo, sr, 1'b1);
  endtask

  task automatic lockoutRun(input string tag, input logic a, input logic [31:0] r, input logic [1:0] p,
                            input logic [3:0] g);
    for (int i = 0; i < 7; i++) cycle({tag, "_locked"}, a, r, p, g, 2'b00, 1'b1);
    cycle({tag, "_release"}, a, r, p, g, 2'b00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'd5000, 2'b10);
    #12;
    pushExpect("reset_state", 4'b0001, 2'b00, 1'b0);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two successive upshifts with the full lockout in between.
    qualifyRun("up1", 1'b1, 32'd1001, 2'b10, 4'b0001, 4'b0010, 2'b10);
    lockoutRun("up1", 1'b1, 32'd1001, 2'b10, 4'b0010);
    qualifyRun("up2", 1'b1, 32'd1001, 2'b10, 4'b0010, 4'b0100, 2'b10);
    lockoutRun("up2", 1'b1, 32'd1001, 2'b10, 4'b0100);

    // A threshold-equal sample breaks the dwell; four fresh samples are needed.
    holdRun("dwell_part", 1'b1, 32'd1001, 2'b10, 4'b0100, 3);
    cycle("dwell_equal", 1'b1, 32'd1000, 2'b10, 4'b0100, 2'b00, 1'b0);
    qualifyRun("dwell_fresh", 1'b1, 32'd1001, 2'b10, 4'b0100, 4'b1000, 2'b10);
    lockoutRun("up3", 1'b1, 32'd5000, 2'b10, 4'b1000);

    holdRun("top_gear", 1'b1, 32'd5000, 2'b10, 4'b1000, 10);

    // Coast down through every gear, then stay in first.
    qualifyRun("dn1", 1'b1, 32'd50, 2'b00, 4'b1000, 4'b0100, 2'b01);
    lockoutRun("dn1", 1'b1, 32'd50, 2'b00, 4'b0100);
    qualifyRun("dn2", 1'b1, 32'd50, 2'b00, 4'b0100, 4'b0010, 2'b01);
    lockoutRun("dn2", 1'b1, 32'd50, 2'b00, 4'b0010);
    qualifyRun("dn3", 1'b1, 32'd50, 2'b00, 4'b0010, 4'b0001, 2'b01);
    lockoutRun("dn3", 1'b1, 32'd50, 2'b00, 4'b0001);
    holdRun("bottom_gear", 1'b1, 32'd50, 2'b00, 4'b0001, 10);

    // Pedal masking and auto gating.
    qualifyRun("up4", 1'b1, 32'd1001, 2'b10, 4'b0001, 4'b0010, 2'b10);
    lockoutRun("up4", 1'b1, 32'd1001, 2'b10, 4'b0010);
    holdRun("accel_mask", 1'b1, 32'd50, 2'b10, 4'b0010, 10);
    holdRun("decel_mask", 1'b1, 32'd5000, 2'b01, 4'b0010, 6);
    holdRun("auto_off", 1'b0, 32'd5000, 2'b00, 4'b0010, 10);
    holdRun("auto_drop_part", 1'b1, 32'd5000, 2'b00, 4'b0010, 3);
    cycle("auto_drop", 1'b0, 32'd5000, 2'b00, 4'b0010, 2'b00, 1'b0);
    qualifyRun("auto_fresh", 1'b1, 32'd5000, 2'b00, 4'b0010, 4'b0100, 2'b10);
    lockoutRun("lock_auto_off", 1'b0, 32'd50, 2'b00, 4'b0100);
    holdRun("down_equal", 1'b1, 32'd100, 2'b00, 4'b0100, 6);

    // Reset in the middle of a lockout leaves no residual lockout.
    qualifyRun("up5", 1'b1, 32'd1001, 2'b10, 4'b0100, 4'b1000, 2'b10);
    for (int i = 0; i < 3; i++) cycle("up5_locked", 1'b1, 32'd1001, 2'b10, 4'b1000, 2'b00, 1'b1);
    rst_n = 1'b0;
    #1;
    pushExpect("reset_lockout", 4'b0001, 2'b00, 1'b0);
    checkOutput();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    qualifyRun("post_reset", 1'b1, 32'd1001, 2'b10, 4'b0001, 4'b0010, 2'b10);
    for (int i = 0; i < 2; i++) cycle("post_reset_locked", 1'b1, 32'd1001, 2'b10, 4'b0010, 2'b00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
